fb_scan_swap: RTL
=================

Name: fb_scan_swap

Overview:
- Downstream consumer of the FTDI framebuffer writer.
- Owns the ping-pong bank select for the dual-bank BRAM framebuffer and streams the display bank out word by word to the panel driver.
- Accepts the writer's `full` flag and returns a one-cycle `swapped` pulse, but only at a display-frame boundary.
- Hides BRAM read latency behind a small credit-controlled output FIFO with valid/ready backpressure.

Parameters:
- ADDR_W, 15, per-bank word address width
- DATA_W, 20, pixel word width (7/7/6 packed)
- FRAME_WORDS, 16896, words per frame (128*128 + 128*4)
- RD_LAT, 2, BRAM read latency in cycles (rd_en to rd_data valid)
- FIFO_DEPTH, 4, output FIFO depth; must be >= RD_LAT+1

Ports:
- clk  in  1  single clock for the whole block (same clock as the writer's BRAM port)
- rst_n  in  1  synchronous, active-low reset
- full  in  1  writer has completed a frame in the write bank
- swapped  out  1  one-cycle pulse: banks exchanged; writer clears `full` and resets its address counter
- wr_bank  out  1  bank the writer targets; BRAM write address = {wr_bank, waddr}
- rd_addr  out  ADDR_W+1  BRAM read address = {rd_bank, word counter}
- rd_en  out  1  BRAM read strobe
- rd_data  in  DATA_W  BRAM read data, valid RD_LAT cycles after rd_en
- pix_data  out  DATA_W  head of output FIFO
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts; a transfer occurs when pix_valid & pix_ready
- pix_last  out  1  qualifies the final word of a frame (word index FRAME_WORDS-1)

Behaviour:
- Reset values: state=WAIT_FIRST, wr_bank=0, rd_bank=1, swapped=0, rd_en=0, rd_addr=0, FIFO empty, pix_valid=0, pix_last=0, in-flight count=0. Reset mid-frame discards in-flight reads and FIFO contents immediately.
- Read issue: rd_en=1 in a cycle only when state=STREAM, issue counter < FRAME_WORDS, and fifo_count + inflight < FIFO_DEPTH. Counting both terms guarantees FIFO overflow is impossible.
- Issue counter: increments on each rd_en; its low ADDR_W bits drive rd_addr. It stops at FRAME_WORDS and never wraps within a frame.
- Return path: a shift pipe of RD_LAT valid bits plus a last-tag follows each rd_en. When the pipe output is valid, rd_data and the tag are pushed into the FIFO.
- In-flight count: +1 on rd_en, -1 on push, net 0 when both occur in the same cycle.
- FIFO: pop on pix_valid & pix_ready. Simultaneous push and pop is allowed at any count, including count=FIFO_DEPTH-1 and count=0 (at count=0, pix_valid is already low, so no pop occurs). pix_last is the tag of the head entry.
- Write bank is always the complement of the read bank.
- States:
  - WAIT_FIRST: no reads, pix_valid=0. When full=1, go to SWAP.
  - STREAM: issue reads. When the word tagged last is popped, go to SWAP if full=1, otherwise to RESTART.
  - SWAP: single cycle. swapped=1, rd_bank toggles, wr_bank toggles, issue counter cleared. Next state is STREAM.
  - RESTART: single cycle. Issue counter cleared, banks unchanged, swapped=0 (the same bank is re-displayed). Next state is STREAM.
- Swap timing: the bank toggle and the swapped pulse happen on the same clock edge that enters STREAM. The first rd_en of the new frame occurs the cycle after SWAP, using the new rd_bank.
- Full handling:
  - full rising mid-frame is deferred until the frame-end pop.
  - full is sampled only in WAIT_FIRST and at the frame-end pop.
  - The writer clears full one cycle after swapped, and at least one whole frame separates swaps, so there is no double swap.
- Swap boundary: the swap never occurs while words of the old bank remain in the FIFO or pipe. The last pop implies both are empty, since no reads are issued past FRAME_WORDS.
- Frame-end timing: if pix_ready is held high, the frame-end pop enters SWAP or RESTART on the next edge, and pix_valid drops for at least RD_LAT+1 cycles during the refill.

Test Plan:
1. Reset, hold full=0 for 100 cycles -> rd_en=0, pix_valid=0, wr_bank=0, rd_bank=1. Then pulse full=1 -> swapped high exactly 1 cycle, rd_bank=0, wr_bank=1, first rd_addr=0x0000 the next cycle, pix_valid high RD_LAT+1 cycles later.
2. pix_ready=1 throughout, writer model clears full on swapped -> exactly 16896 transfers per frame, pix_last only on transfer 16896, rd_addr spans 0x0000..0x41FF. With full=0 at the end: RESTART, no swapped, same bank repeated.
3. Random pix_ready (about 30% duty) -> fifo_count+inflight never exceeds 4, no word lost or duplicated (scoreboard against BRAM model tagged with address), order preserved.
4. Assert full at word 5000 of a frame -> swapped only after the pix_last pop; next frame reads bank 1-old, i.e. rd_addr MSB flips.
5. Assert rst_n=0 for 1 cycle at word 8000, pix_ready=1 -> next cycle pix_valid=0, rd_en=0, wr_bank=0, state WAIT_FIRST. No stale word from before the reset ever appears on pix_data.
6. full held high continuously (misbehaving writer) -> exactly one swap per 16896-word frame, never two swaps within the same frame.

Source files
------------

// File: rtl/fb_scan_swap.sv
// Ping-pong framebuffer scan-out: owns bank select, streams the display
// bank through a credit-limited FIFO and swaps banks only at frame end.
module fb_scan_swap #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 20,
  parameter int FRAME_WORDS = 16896,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              full,
  output logic              swapped,
  output logic              wr_bank,
  output logic [ADDR_W:0]   rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  localparam int CW = ADDR_W + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FW      = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] FW_LAST = CW'(FRAME_WORDS - 1);
  localparam logic [OW-1:0] DEPTH   = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    WAIT_FIRST, STREAM, SWAP, RESTART
  } state_t;

  state_t state, state_nx;

  logic              rd_bank;
  logic [CW-1:0]     cnt;
  logic [OW-1:0]     fcnt;
  logic [OW-1:0]     infl;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pt;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic              fl [FIFO_DEPTH];
  logic              push;
  logic              pop;
  logic              last_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign push      = pv[RD_LAT-1];
  assign pix_valid = (fcnt != '0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = fd[head];
  assign pix_last  = pix_valid & fl[head];
  assign last_pop  = pop & fl[head];
  assign wr_bank   = ~rd_bank;
  assign rd_addr   = rd_en ? {rd_bank, cnt[ADDR_W-1:0]} : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_FIRST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_FIRST: if (full) state_nx = SWAP;
      STREAM:     if (last_pop) state_nx = full ? SWAP : RESTART;
      SWAP:       state_nx = STREAM;
      RESTART:    state_nx = STREAM;
    endcase
  end

  // Credits cover both queued words and reads still in the BRAM pipe.
  always_comb begin
    rd_en   = 1'b0;
    swapped = 1'b0;
    unique case (state)
      STREAM:  rd_en = (cnt < FW) && ((fcnt + infl) < DEPTH);
      SWAP:    swapped = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank <= 1'b1;
      cnt     <= '0;
      fcnt    <= '0;
      infl    <= '0;
      pv      <= '0;
      pt      <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (state == SWAP) rd_bank <= ~rd_bank;
      if (state == SWAP || state == RESTART) cnt <= '0;
      else if (rd_en)                        cnt <= cnt + 1'b1;
      pv[0] <= rd_en;
      pt[0] <= rd_en && (cnt == FW_LAST);
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      infl <= infl + OW'(rd_en) - OW'(push);
      fcnt <= fcnt + OW'(push) - OW'(pop);
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fd[tail] <= rd_data;
      fl[tail] <= pt[RD_LAT-1];
    end
  end

endmodule
